// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
// hazard_controller_if : pipeline-side signals of the hazard controller
// Rev 1.0
// ============================================================================
interface hazard_controller_if;
   logic        forward;
   logic        id_valid;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic        two_src;
   logic        exe_wb;
   logic        exe_mem_read;
   logic [3:0]  exe_dest;
   logic        mem_wb;
   logic [3:0]  mem_dest;
   logic        mem_req;
   logic        mem_ready;
   logic        branch_taken;
   logic        stat_clr;
   logic        freeze_pc;
   logic        freeze_if_id;
   logic        bubble_id_exe;
   logic        freeze_all;
   logic        flush_if_id;
   logic        mem_timeout;
   logic [15:0] stall_count;

   modport master (
      output forward, id_valid, src1, src2, two_src, exe_wb, exe_mem_read, exe_dest,
             mem_wb, mem_dest, mem_req, mem_ready, branch_taken, stat_clr,
      input  freeze_pc, freeze_if_id, bubble_id_exe, freeze_all, flush_if_id,
             mem_timeout, stall_count
   );

   modport slave (
      input  forward, id_valid, src1, src2, two_src, exe_wb, exe_mem_read, exe_dest,
             mem_wb, mem_dest, mem_req, mem_ready, branch_taken, stat_clr,
      output freeze_pc, freeze_if_id, bubble_id_exe, freeze_all, flush_if_id,
             mem_timeout, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// hazard_controller : stall/bubble/flush/freeze sequencing for the 5-stage core
// Rev 1.0
// ============================================================================
module hazard_controller #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input wire logic          clk,
   input wire logic          rst_n,
   hazard_controller_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_t;

   localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_count_q, stall_count_d;

   logic w_match_exe, w_match_mem, w_hazard;
   logic w_mem_stall, w_timeout;
   logic w_freeze_all, w_flush, w_stall;

   assign w_match_exe = (bus.src1 == bus.exe_dest) | (bus.two_src & (bus.src2 == bus.exe_dest));
   assign w_match_mem = (bus.src1 == bus.mem_dest) | (bus.two_src & (bus.src2 == bus.mem_dest));

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign w_hazard = bus.forward
                   ? (bus.id_valid & bus.exe_wb & bus.exe_mem_read & w_match_exe)
                   : (bus.id_valid & ((bus.exe_wb & w_match_exe) | (bus.mem_wb & w_match_mem)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= 8'd0;
         stall_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      w_mem_stall = 1'b0;
      w_timeout   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               w_mem_stall = 1'b1;
               state_d     = ST_MEM_WAIT;
               wait_cnt_d  = 8'd1;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else begin
               w_mem_stall = 1'b1;
               if (wait_cnt_q == C_WAIT_LAST) begin
                  state_d    = ST_TIMEOUT;
                  wait_cnt_d = 8'd0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
         end
         ST_TIMEOUT: begin
            w_timeout = 1'b1;
            state_d   = ST_RUN;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   assign w_freeze_all = rst_n & w_mem_stall;
   assign w_flush      = rst_n & bus.branch_taken & ~w_mem_stall;
   assign w_stall      = rst_n & w_hazard & ~bus.branch_taken & ~w_mem_stall;

   always_comb begin
      stall_count_d = stall_count_q;
      if (bus.stat_clr) begin
         stall_count_d = 16'd0;
      end else if (w_stall && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   assign bus.freeze_all    = w_freeze_all;
   assign bus.flush_if_id   = w_flush;
   assign bus.bubble_id_exe = w_stall;
   assign bus.freeze_pc     = w_stall | w_freeze_all;
   assign bus.freeze_if_id  = w_stall | w_freeze_all;
   assign bus.mem_timeout   = rst_n & w_timeout;
   assign bus.stall_count   = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// tb_hazard_controller : directed and randomized checks against a cycle model
// Rev 1.0
// ============================================================================
module tb_hazard_controller;
   localparam int TO = 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   hazard_controller_if bus ();

   hazard_controller #(.MEM_TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {freeze_pc, freeze_if_id, bubble_id_exe, freeze_all, flush_if_id, mem_timeout}
   logic [5:0] obs;
   assign obs = {bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe,
                 bus.freeze_all, bus.flush_if_id, bus.mem_timeout};

   // Reference: counts consecutive frozen cycles of one access against TO.
   int         m_frozen;
   bit         m_pulse;
   int         m_cnt;
   bit         e_freeze;
   bit         e_stall;
   logic [5:0] exp_o;

   function automatic bit reads(input logic [3:0] d);
      return (bus.src1 == d) || (bus.two_src && (bus.src2 == d));
   endfunction

   task automatic model_eval();
      bit haz, fz, fl, st;
      if (bus.forward)
         haz = bus.id_valid && bus.exe_wb && bus.exe_mem_read && reads(bus.exe_dest);
      else
         haz = bus.id_valid && ((bus.exe_wb && reads(bus.exe_dest)) ||
                                (bus.mem_wb && reads(bus.mem_dest)));
      fz = !m_pulse && !bus.mem_ready && ((m_frozen > 0) || bus.mem_req);
      fl = bus.branch_taken && !fz;
      st = haz && !bus.branch_taken && !fz;
      if (!rst_n) begin
         fz = 0; fl = 0; st = 0;
      end
      e_freeze = fz;
      e_stall  = st;
      exp_o    = {st | fz, st | fz, st, fz, fl, m_pulse && rst_n};
   endtask

   task automatic tick();
      model_eval();
      if (!rst_n) begin
         m_frozen = 0; m_pulse = 0; m_cnt = 0;
      end else begin
         if (bus.stat_clr) m_cnt = 0;
         else if (e_stall && m_cnt < 65535) m_cnt++;
         if (m_pulse) begin
            m_pulse = 0; m_frozen = 0;
         end else if (e_freeze) begin
            m_frozen++;
            if (m_frozen == TO) begin
               m_pulse = 1; m_frozen = 0;
            end
         end else begin
            m_frozen = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.forward = 1'b1; bus.id_valid = 1'b0; bus.src1 = 4'd0; bus.src2 = 4'd0;
      bus.two_src = 1'b0; bus.exe_wb = 1'b0; bus.exe_mem_read = 1'b0; bus.exe_dest = 4'd0;
      bus.mem_wb = 1'b0; bus.mem_dest = 4'd0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
      bus.branch_taken = 1'b0; bus.stat_clr = 1'b0;
   endtask

   task automatic set_load_use();
      bus.forward = 1'b1; bus.id_valid = 1'b1; bus.exe_wb = 1'b1;
      bus.exe_mem_read = 1'b1; bus.exe_dest = 4'd3; bus.src1 = 4'd3;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_load_use();
      bus.mem_req = 1'b1; bus.branch_taken = 1'b1;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b000000) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 000000", obs);
      end
      tick();
      tick();
      rst_n = 1'b1;
      idle_inputs();
      #2; model_eval();
      n_tests++;
      if (bus.stall_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
      end
      n_tests++;
      if (obs !== exp_o) begin
         n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, exp_o);
      end
      tick();
   endtask

   task automatic test_load_use();
      idle_inputs();
      set_load_use();
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b111000 || obs !== exp_o) begin
         n_fail++; $display("FAIL load_use_bubble: got %b expected 111000 (model %b)", obs, exp_o);
      end
      tick();
      bus.exe_wb = 1'b0; bus.exe_mem_read = 1'b0; bus.mem_wb = 1'b1; bus.mem_dest = 4'd3;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b000000 || obs !== exp_o) begin
         n_fail++; $display("FAIL load_use_release: got %b expected 000000", obs);
      end
      n_tests++;
      if (bus.stall_count !== 16'd1) begin
         n_fail++; $display("FAIL load_use_count: got %0d expected 1", bus.stall_count);
      end
      tick();
   endtask

   task automatic test_no_forward();
      idle_inputs();
      bus.forward = 1'b0; bus.id_valid = 1'b1; bus.two_src = 1'b1;
      bus.src1 = 4'd7; bus.src2 = 4'd5; bus.mem_wb = 1'b1; bus.mem_dest = 4'd5;
      #2; model_eval();
      n_tests++;
      if (bus.bubble_id_exe !== 1'b1 || obs !== exp_o) begin
         n_fail++; $display("FAIL nofwd_stall: got %b expected bubble=1 (model %b)", obs, exp_o);
      end
      bus.forward = 1'b1;
      #2; model_eval();
      n_tests++;
      if (bus.bubble_id_exe !== 1'b0 || obs !== exp_o) begin
         n_fail++; $display("FAIL fwd_nostall: got %b expected bubble=0 (model %b)", obs, exp_o);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      int nfz, nto;
      nfz = 0; nto = 0;
      idle_inputs();
      bus.mem_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = (i == 3);
         #2; model_eval();
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL mem_wait_cyc%0d: got %b expected %b", i, obs, exp_o);
         end
         nfz += int'(bus.freeze_all);
         nto += int'(bus.mem_timeout);
         tick();
      end
      idle_inputs();
      n_tests++;
      if (nfz != 3 || nto != 0) begin
         n_fail++; $display("FAIL mem_wait_total: got freeze=%0d timeout=%0d expected 3/0", nfz, nto);
      end
   endtask

   task automatic test_timeout();
      logic [6:0] fz_seq, to_seq;
      idle_inputs();
      bus.mem_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #2; model_eval();
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL timeout_cyc%0d: got %b expected %b", i, obs, exp_o);
         end
         fz_seq[i] = bus.freeze_all;
         to_seq[i] = bus.mem_timeout;
         tick();
      end
      n_tests++;
      if (fz_seq !== 7'b1101111 || to_seq !== 7'b0010000) begin
         n_fail++; $display("FAIL timeout_seq: got fz=%b to=%b expected 1101111/0010000", fz_seq, to_seq);
      end
      bus.mem_ready = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic test_branch();
      idle_inputs();
      set_load_use();
      bus.branch_taken = 1'b1;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b000010 || obs !== exp_o) begin
         n_fail++; $display("FAIL branch_priority: got %b expected 000010", obs);
      end
      bus.mem_req = 1'b1;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b110100 || obs !== exp_o) begin
         n_fail++; $display("FAIL freeze_priority: got %b expected 110100", obs);
      end
      tick();
      bus.mem_ready = 1'b1;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b000010 || obs !== exp_o) begin
         n_fail++; $display("FAIL branch_after_release: got %b expected 000010", obs);
      end
      n_tests++;
      if (bus.stall_count !== 16'(m_cnt)) begin
         n_fail++; $display("FAIL branch_count: got %0d expected %0d", bus.stall_count, m_cnt);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      bus.mem_req = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b000000) begin
         n_fail++; $display("FAIL reset_in_wait: got %b expected 000000", obs);
      end
      tick();
      rst_n = 1'b1;
      bus.mem_req = 1'b0;
      #2; model_eval();
      n_tests++;
      if (obs !== 6'b000000 || obs !== exp_o) begin
         n_fail++; $display("FAIL reset_back_to_run: got %b expected 000000", obs);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst_n            = ($urandom_range(0, 63) != 0);
         bus.forward      = 1'($urandom);
         bus.id_valid     = ($urandom_range(0, 3) != 0);
         bus.src1         = 4'($urandom_range(0, 3));
         bus.src2         = 4'($urandom_range(0, 3));
         bus.two_src      = 1'($urandom);
         bus.exe_wb       = 1'($urandom);
         bus.exe_mem_read = 1'($urandom);
         bus.exe_dest     = 4'($urandom_range(0, 3));
         bus.mem_wb       = 1'($urandom);
         bus.mem_dest     = 4'($urandom_range(0, 3));
         bus.mem_req      = ($urandom_range(0, 2) == 0);
         bus.mem_ready    = ($urandom_range(0, 3) == 0);
         bus.branch_taken = ($urandom_range(0, 9) == 0);
         bus.stat_clr     = ($urandom_range(0, 49) == 0);
         #2; model_eval();
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL random_out_%0d: got %b expected %b", i, obs, exp_o);
         end
         n_tests++;
         if (bus.stall_count !== 16'(m_cnt)) begin
            n_fail++; $display("FAIL random_cnt_%0d: got %0d expected %0d", i, bus.stall_count, m_cnt);
         end
         tick();
      end
      rst_n = 1'b1;
      idle_inputs();
      bus.mem_ready = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic test_saturate();
      idle_inputs();
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      set_load_use();
      for (int i = 0; i < 65540; i++) begin
         if ((i % 8192) == 0) begin
            #2; model_eval();
            n_tests++;
            if (bus.stall_count !== 16'(m_cnt)) begin
               n_fail++; $display("FAIL sat_progress_%0d: got %0d expected %0d", i, bus.stall_count, m_cnt);
            end
         end
         tick();
      end
      n_tests++;
      if (bus.stall_count !== 16'hFFFF) begin
         n_fail++; $display("FAIL sat_hold: got %h expected ffff", bus.stall_count);
      end
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      #2; model_eval();
      n_tests++;
      if (bus.stall_count !== 16'd0 || bus.stall_count !== 16'(m_cnt)) begin
         n_fail++; $display("FAIL stat_clr: got %0d expected 0", bus.stall_count);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      m_frozen = 0;
      m_pulse  = 0;
      m_cnt    = 0;
      rst_n    = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_no_forward();
      test_mem_wait();
      test_timeout();
      test_branch();
      test_reset_mid_wait();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
